// File: rtl/latch_drv_pkg.sv
// Shared types and sizing helpers for the latch bank write-and-verify driver.
package latch_drv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    // Width of a down-counter that must hold the longest phase length.
    function automatic int phase_w(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
        int m;
        m = setup_cyc;
        if (pulse_cyc > m) m = pulse_cyc;
        if (hold_cyc > m) m = hold_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/latch_load_driver_phase_timer.sv
// Loadable down-counter; zero marks the last cycle of the current phase.
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/simple_latch.sv
// One-bit level-sensitive latch cell of the bank: transparent while load is high.
module simple_latch (
    input  logic data,
    input  logic load,
    output logic dout
);

    always_latch begin
        if (load)
            dout <= data;
    end

endmodule

// File: rtl/latch_load_driver.sv
// Writes a word into a bank of one-bit latches one bit at a time, LSB first,
// and reads each latch back after its strobe to flag mismatching bits.
module latch_load_driver
    import latch_drv_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic [WIDTH-1:0] lat_data,
    output logic [WIDTH-1:0] lat_load,
    input  logic [WIDTH-1:0] lat_dout,
    output logic             done,
    output logic [WIDTH-1:0] err_mask,
    output logic             err
);

    localparam int PW = phase_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    tmr_val;
    logic             tmr_load, tmr_zero;
    logic [WIDTH-1:0] bit_sel, chk_mask;

    phase_timer #(.W(PW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_SETUP;
            S_SETUP: if (tmr_zero) state_nxt = S_PULSE;
            S_PULSE: if (tmr_zero) state_nxt = S_HOLD;
            S_HOLD:  if (tmr_zero) state_nxt = S_CHECK;
            S_CHECK: state_nxt = (idx == IDX_LAST) ? S_DONE : S_SETUP;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every phase entry is a state change, so the timer reloads on any transition.
    always_comb begin
        in_ready = (state == S_IDLE);
        bit_sel  = WIDTH'(1) << idx;
        chk_mask = '0;
        if (state == S_CHECK && lat_dout[idx] != lat_data[idx])
            chk_mask = bit_sel;
        tmr_load = (state_nxt != state);
        case (state_nxt)
            S_SETUP: tmr_val = PW'(SETUP_CYC - 1);
            S_PULSE: tmr_val = PW'(PULSE_CYC - 1);
            S_HOLD:  tmr_val = PW'(HOLD_CYC - 1);
            default: tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_data <= '0;
            lat_load <= '0;
            err_mask <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            idx      <= '0;
        end else begin
            lat_load <= (state_nxt == S_PULSE) ? bit_sel : '0;
            done     <= (state_nxt == S_DONE);
            if (state == S_IDLE && in_valid) begin
                lat_data <= in_word;
                err_mask <= '0;
                err      <= 1'b0;
                idx      <= '0;
            end
            if (state == S_CHECK) begin
                err_mask <= err_mask | chk_mask;
                if (idx == IDX_LAST)
                    err <= |(err_mask | chk_mask);
                else
                    idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_latch_load_driver.sv
// Bench for latch_load_driver: latch bank model with per-bit dout forcing,
// a cycle-level strobe model and a scoreboard of expected check results.
module tb_latch_load_driver;

    localparam int W = 4;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
    localparam int PER = S + P + H + 1;
    localparam int DONE_K = W * PER + 1;

    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] dout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_word;
    logic [W-1:0] lat_data, lat_load, lat_dout, lat_q;
    logic [W-1:0] fault_en, fault_val;
    logic         done;
    logic [W-1:0] err_mask;
    logic         err;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    latch_load_driver #(
        .WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .lat_data (lat_data),
        .lat_load (lat_load),
        .lat_dout (lat_dout),
        .done     (done),
        .err_mask (err_mask),
        .err      (err)
    );

    for (genvar i = 0; i < W; i++) begin : g_bank
        simple_latch u_lat (.data(lat_data[i]), .load(lat_load[i]), .dout(lat_q[i]));
    end
    assign lat_dout = (lat_q & ~fault_en) | (fault_val & fault_en);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Cycle model: k counts cycles since the accepting edge while a write is active.
    bit           mon_en = 1'b0;
    bit           active = 1'b0;
    bit           expect_b2b = 1'b0;
    int           k = 0;
    int           cyc = 0;
    int           done_cyc = -100;
    logic [W-1:0] cur_word = '0;

    always @(negedge clk) begin
        logic [W-1:0] exp_load;
        exp_t         e;
        cyc++;
        if (mon_en) begin
            exp_load = '0;
            if (active && k >= 1 && k < DONE_K &&
                ((k - 1) % PER == S || (k - 1) % PER == S + 1))
                exp_load = W'(1) << ((k - 1) / PER);
            chk("lat_load", lat_load, exp_load);
            chk("onehot", $onehot0(lat_load), 1);
            chk("done", done, active && k == DONE_K);
            chk("in_ready", in_ready, !active);
            chk("lat_data", lat_data, cur_word);
            if (active && k == 1) begin
                chk("mask_clr", err_mask, 0);
                chk("err_clr", err, 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("err_mask", err_mask, e.mask);
                    chk("err", err, |e.mask);
                    chk("bank", lat_dout, e.dout);
                end
                done_cyc = cyc;
            end
        end
        if (rst) begin
            active   = 1'b0;
            cur_word = '0;
            sb.delete();
        end else if (in_valid && !active) begin
            if (expect_b2b) begin
                chk("b2b_gap", cyc - done_cyc, 1);
                expect_b2b = 1'b0;
            end
            active   = 1'b1;
            k        = 1;
            cur_word = in_word;
            e.mask   = fault_en & (fault_val ^ in_word);
            e.dout   = (in_word & ~fault_en) | (fault_val & fault_en);
            sb.push_back(e);
        end else if (active) begin
            k++;
            if (k > DONE_K) active = 1'b0;
        end
    end

    // Raises in_valid, returns one cycle after the handshake with in_valid low.
    task automatic send(input logic [W-1:0] w, input bit keep_valid);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_word  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_word = '0;
        fault_en = '0; fault_val = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_load", lat_load, 0);
        chk("rst_data", lat_data, 0);
        chk("rst_mask", err_mask, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);

        // single write, good bank
        send(4'hA, 1'b0);
        wait_done();

        // latch 2 stuck at 0
        fault_en = 4'b0100; fault_val = 4'b0000;
        send(4'hF, 1'b0);
        wait_done();
        fault_en = '0;

        // back-to-back with in_valid held high
        send(4'h5, 1'b1);
        in_word    = 4'h3;
        expect_b2b = 1'b1;
        send(4'h3, 1'b0);
        wait_done();
        chk("b2b_seen", expect_b2b, 0);

        // traffic while busy is ignored; send returns in cycle k=1
        send(4'h9, 1'b0);
        repeat (PER + S) @(posedge clk);
        #1;
        chk("busy_pulse", lat_load, 4'b0010);
        in_word = 4'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done();

        // reset during PULSE of bit 2
        send(4'hC, 1'b0);
        repeat (2 * PER + S) @(posedge clk);
        #1;
        chk("abort_pulse", lat_load, 4'b0100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_load", lat_load, 0);
        chk("abort_data", lat_data, 0);
        chk("abort_ready", in_ready, 1);
        repeat (DONE_K) @(posedge clk);
        #1;
        send(4'h6, 1'b0);
        wait_done();

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/latch_load_driver.md
# latch_load_driver

Sequential write-and-verify driver for a bank of WIDTH one-bit level-sensitive latches, each with `data`/`load`/`dout`. It accepts a parallel word over a valid/ready handshake and strobes each latch's `load` in turn, LSB first, with programmable setup, pulse and hold times. After each strobe it reads the latch's `dout` back and reports per-bit mismatches. It sits between a register-write source and the latch bank; it is the writer end of the latch's `data`/`load` interface.

## Interface
- `WIDTH`, 8: number of latches (word width), ≥1
- `SETUP_CYC`, 1: cycles data is stable before `load` rises, ≥1
- `PULSE_CYC`, 2: cycles `load` is held high, ≥1
- `HOLD_CYC`, 1: cycles data is held after `load` falls, ≥1

One clock; reset is synchronous and active-high.
- `clk` input 1: clock, rising-edge
- `rst` input 1: synchronous active-high reset
- `in_valid` input 1: `in_word` is valid
- `in_ready` output 1: block is idle and accepts a word
- `in_word` input WIDTH: word to write into the latch bank
- `lat_data` output WIDTH: data to latch bank, bit i goes to latch i
- `lat_load` output WIDTH: one-hot-or-zero load strobes, bit i goes to latch i
- `lat_dout` input WIDTH: readback from latch bank
- `done` output 1: one-cycle pulse when the word has been written and checked
- `err_mask` output WIDTH: bit i set if latch i read back wrong; valid when `done` is high, held until the next accept
- `err` output 1: OR of `err_mask`; same validity as `err_mask`

## Operation
- States: IDLE, SETUP, PULSE, HOLD, CHECK, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: register `in_word` into `lat_data`, clear `err_mask`/`err`, set bit index to 0, go to SETUP.
- SETUP: stay SETUP_CYC cycles with `lat_load`=0, then go to PULSE.
- PULSE: stay PULSE_CYC cycles with `lat_load` = (1 << idx), then go to HOLD.
- HOLD: stay HOLD_CYC cycles with `lat_load`=0, then go to CHECK.
- CHECK: one cycle.
  - Compare `lat_dout[idx]` with `lat_data[idx]`; on mismatch set `err_mask[idx]`.
  - If idx==WIDTH-1, go to DONE; otherwise increment idx and go to SETUP.
- DONE: one cycle with `done`=1 and `err` = |`err_mask`, then go to IDLE.
- `lat_data` holds the full word from the accept until the next accept. Only the strobed bit is captured.
- At most one `lat_load` bit is high in any cycle.
- `in_valid` outside IDLE is ignored. Upstream must hold `in_valid`/`in_word` until the handshake.
- Reset values: state IDLE, `lat_load`=0, `lat_data`=0, `err_mask`=0, `err`=0, `done`=0, idx=0. `in_ready` is decoded from the state, so it reads 1 in the cycle after the reset edge.
- Reset mid-operation: on the next edge, `lat_load` drops to 0 and all outputs take their reset values. No `done` is produced for the aborted word.

## Timing
- Per-bit period P = SETUP_CYC + PULSE_CYC + HOLD_CYC + 1.
- Accept edge to `done` high: WIDTH·P + 1 cycles. Next accept can happen no earlier than 1 cycle after `done`.
- `lat_dout` is sampled at the rising edge that ends the CHECK cycle.
  - Latency through the latch from `lat_load` must be under HOLD_CYC+1 cycles.
  - The latch being checked must be transparent at or before the `load` fall.
- Phase counter width: $clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1). Index width: $clog2(WIDTH), minimum 1.
- All outputs are registered except `in_ready`, which is decoded from the state register.

## Structure
- Package `latch_drv_pkg`: state enum, and a function giving the phase-counter width from the three cycle parameters.
- Sub-module `phase_timer`: loadable down-counter with a `zero` flag, reused for SETUP/PULSE/HOLD.
- The bench instantiates WIDTH copies of the existing one-bit `simple_latch` as the bank model, with a fault-injection option that forces `dout` per bit.

## Test plan
All scenarios use WIDTH=4, SETUP=1, PULSE=2, HOLD=1, so P=5.
- Single write: `in_word`=4'hA with a good bank.
  - `lat_load` shows 0001, 0010, 0100, 1000, each high 2 cycles and 5 cycles apart.
  - `done` is high at accept+21; `err`=0; bank `dout` reads 4'hA.
- Stuck fault: force latch 2 `dout`=0, write 4'hF → at `done`, `err_mask`=4'b0100 and `err`=1.
- Back-to-back: hold `in_valid` with 4'h5 then 4'h3.
  - Second accept occurs exactly 1 cycle after the first `done`.
  - `err_mask` is cleared on the second accept; final bank value is 4'h3.
- Busy ignore: change `in_word` to 4'h0 and pulse `in_valid` during PULSE of bit 1 → no effect; the write completes with 4'h9 as accepted.
- Reset mid-op: assert `rst` during PULSE of bit 2.
  - Next edge: `lat_load`=0, `lat_data`=0, no `done`.
  - `in_ready`=1 after release; a new write of 4'h6 completes with `err`=0.
- One-hot check: assert throughout all scenarios that `lat_load` is never multi-hot and is 0 outside PULSE.
